// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared encodings for the load/store stage: access-size codes, FSM state
// constants and a helper that classifies a request as misaligned/illegal.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   // Access size encodings as driven by the controller on mem_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Access FSM states
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT_R = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // True when an access of this size at this byte offset cannot be issued:
   // halves need an even address, words a word-aligned one, and the
   // reserved size code is always rejected.
   function automatic logic size_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// lane_align
// Purely combinational byte-lane logic for the load/store stage.
//   Request side (current controller request):
//     req_size, req_addr_lo, req_wdata -> req_be, req_lanes, req_bad
//   Load side (registered access attributes + bus read data):
//     ld_size, ld_addr_lo, ld_unsigned, ld_rdata -> ld_data
// ---------------------------------------------------------------------------
module lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   output logic [31:0] req_lanes,
   output logic        req_bad,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shifted;

   // Byte enables and lane replication for the store path. Replicating the
   // right-justified store data onto every lane means the memory only needs
   // the byte enables to pick the right bytes.
   always_comb begin
      req_be    = 4'b0000;
      req_lanes = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            req_be    = 4'b0001 << req_addr_lo;
            req_lanes = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            req_be    = 4'b0011 << req_addr_lo;
            req_lanes = {2{req_wdata[15:0]}};
         end
         SZ_WORD: begin
            req_be    = 4'b1111;
            req_lanes = req_wdata;
         end
         default: begin
            req_be    = 4'b0000;
            req_lanes = req_wdata;
         end
      endcase
   end

   assign req_bad = size_misaligned(req_size, req_addr_lo);

   // Shift the addressed lane down to bit 0, then extend to 32 bits
   assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = ld_rdata;
      case (ld_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'h000000, ld_shifted[7:0]}
                                        : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         SZ_HALF: ld_data = ld_unsigned ? {16'h0000, ld_shifted[15:0]}
                                        : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store stage behind the single-cycle datapath. Converts memread/
// memwrite from the controller into a req/gnt/rvalid bus access and returns
// aligned, extended load data. stall holds the PC/regfile while an access is
// in flight.
//
// Ports:
//   clk, reset (async, active low)
//   memread, memwrite, mem_size[1:0], load_unsigned, alu_result[31:0],
//   writedata[31:0]                       - request from the datapath
//   readdata[31:0], stall, access_err      - results to the datapath
//   bus_req, bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0]
//                                          - request to the data bus
//   bus_gnt, bus_rvalid, bus_rdata[31:0]   - responses from the data bus
//
// Parameter TIMEOUT: bus cycles spent in REQ+WAIT_R before abandoning.
// Build option STORE_BUFFER_EN: when defined, stores are posted into a
// one-entry write buffer and drained in the background.
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [1:0]  mem_size,
   input  logic        load_unsigned,
   input  logic [31:0] alu_result,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        access_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

`ifdef STORE_BUFFER_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   // The counter is compared against the last allowed cycle, so an access
   // that never completes spends exactly TIMEOUT cycles on the bus.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [1:0]  alo_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] rdata_q;
   logic        tmo_q;
   logic        drain_q;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic        lane_bad;
   logic [31:0] lane_ld;

   logic        any_req;
   logic        idle_bad;
   logic        idle_go;
   logic        buf_take;
   logic        expired;
   logic        idle_err;

   lane_align u_lane_align (
      .req_size    (mem_size),
      .req_addr_lo (alu_result[1:0]),
      .req_wdata   (writedata),
      .req_be      (lane_be),
      .req_lanes   (lane_wdata),
      .req_bad     (lane_bad),
      .ld_size     (size_q),
      .ld_addr_lo  (alo_q),
      .ld_unsigned (uns_q),
      .ld_rdata    (bus_rdata),
      .ld_data     (lane_ld)
   );

   assign any_req  = memread | memwrite;
   assign idle_bad = any_req & ((memread & memwrite) | lane_bad);
   assign idle_go  = any_req & ~idle_bad;
   assign buf_take = BUF_EN & idle_go & memwrite;
   assign expired  = (cnt_q == CNT_LAST);
   assign idle_err = reset & (state_q == S_IDLE) & idle_bad;

   // A rejected request retires in the same cycle, so its zero result has to
   // be visible combinationally rather than after the next edge.
   assign readdata = idle_err ? 32'h0000_0000 : rdata_q;

   // Bus fields are only driven while a request is outstanding
   assign bus_req   = (state_q == S_REQ);
   assign bus_we    = bus_req & we_q;
   assign bus_addr  = bus_req ? addr_q  : 32'h0000_0000;
   assign bus_be    = bus_req ? be_q    : 4'b0000;
   assign bus_wdata = bus_req ? wdata_q : 32'h0000_0000;

   // Datapath handshake. Stall is held low and errors suppressed while reset
   // is asserted so a controller still presenting a request cannot freeze
   // the datapath during reset. A background store drain only stalls the
   // datapath when the controller wants another access.
   always_comb begin
      stall      = 1'b0;
      access_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall      = idle_go & ~buf_take;
            access_err = idle_bad;
         end
         S_REQ: begin
            stall      = drain_q ? any_req : 1'b1;
            access_err = drain_q & ~bus_gnt & expired;
         end
         S_WAIT_R: stall = 1'b1;
         S_RESP:   access_err = tmo_q;
         default: begin
            stall      = 1'b0;
            access_err = 1'b0;
         end
      endcase
      if (!reset) begin
         stall      = 1'b0;
         access_err = 1'b0;
      end
   end

   // Access FSM, timeout counter and registered access attributes. The same
   // attribute registers double as the posted-write buffer when enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 32'h0000_0000;
         alo_q   <= 2'b00;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0000_0000;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         rdata_q <= 32'h0000_0000;
         tmo_q   <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (idle_bad) begin
                  rdata_q <= 32'h0000_0000;
               end else if (idle_go) begin
                  addr_q  <= {alu_result[31:2], 2'b00};
                  alo_q   <= alu_result[1:0];
                  be_q    <= lane_be;
                  wdata_q <= lane_wdata;
                  we_q    <= memwrite;
                  size_q  <= mem_size;
                  uns_q   <= load_unsigned;
                  cnt_q   <= 8'd0;
                  tmo_q   <= 1'b0;
                  drain_q <= buf_take;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus_gnt) begin
                  cnt_q <= cnt_q + 8'd1;
                  if (drain_q) begin
                     drain_q <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= we_q ? S_RESP : S_WAIT_R;
                  end
               end else if (expired) begin
                  if (drain_q) begin
                     drain_q <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     tmo_q   <= 1'b1;
                     rdata_q <= 32'h0000_0000;
                     state_q <= S_RESP;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_WAIT_R: begin
               if (bus_rvalid) begin
                  rdata_q <= lane_ld;
                  state_q <= S_RESP;
               end else if (expired) begin
                  tmo_q   <= 1'b1;
                  rdata_q <= 32'h0000_0000;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: begin
               tmo_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit. Each access is planned as a timeline
// of per-cycle slots (inputs plus expected outputs) derived from the access
// rules; a negedge compare process checks every slot, and a few literal
// expectations pin the planned values afterwards.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic        load_unsigned = 1'b0;
   logic [31:0] alu_result = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        stall;
   logic        access_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   mem_access_unit dut (
      .clk           (clk),
      .reset         (reset),
      .memread       (memread),
      .memwrite      (memwrite),
      .mem_size      (mem_size),
      .load_unsigned (load_unsigned),
      .alu_result    (alu_result),
      .writedata     (writedata),
      .readdata      (readdata),
      .stall         (stall),
      .access_err    (access_err),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_be        (bus_be),
      .bus_wdata     (bus_wdata),
      .bus_gnt       (bus_gnt),
      .bus_rvalid    (bus_rvalid),
      .bus_rdata     (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_stall;
      logic        e_req;
      logic        e_err;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_rd;
   } slot_t;

   slot_t       slots [1024];
   logic        dut_stall [1024];
   logic        dut_req   [1024];
   logic        dut_err   [1024];
   logic        dut_we    [1024];
   logic [3:0]  dut_be    [1024];
   logic [31:0] dut_wdata [1024];
   logic [31:0] dut_rd    [1024];

   int          plan_t = 0;
   logic [31:0] model_rd = 32'h0;
   int          cur_idx = 0;
   bit          running = 1'b0;
   int          checks = 0;
   int          errors = 0;

   int lw_t, lb_t, lbu_t, sh_t, bad_t, tmo_t;

   // One comparison: count it, report it on mismatch
   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   // Drive one slot's inputs onto the DUT
   task automatic applyStimulus(input slot_t s);
      memread       = s.rd;
      memwrite      = s.wr;
      mem_size      = s.sz;
      load_unsigned = s.uns;
      alu_result    = s.addr;
      writedata     = s.wd;
      bus_gnt       = s.gnt;
      bus_rvalid    = s.rvalid;
      bus_rdata     = s.rdata;
   endtask

   function automatic int nbytesOf(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Enabled lanes are the nb bytes starting at the byte offset
   function automatic logic [3:0] beOf(input logic [1:0] sz, input logic [1:0] a);
      logic [3:0] be;
      int nb;
      nb = nbytesOf(sz);
      for (int k = 0; k < 4; k++) be[k] = (k >= int'(a)) && (k < int'(a) + nb);
      return be;
   endfunction

   // Store data copied around every lane
   function automatic logic [31:0] lanesOf(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] v;
      int nb;
      nb = nbytesOf(sz);
      for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % nb) +: 8];
      return v;
   endfunction

   // Gather the addressed bytes, then fill the upper bytes for sign extension
   function automatic logic [31:0] extractOf(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] a, input logic [31:0] rdata);
      logic [31:0] v;
      int nb;
      nb = nbytesOf(sz);
      v = 32'h0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = rdata[8*(int'(a) + k) +: 8];
      if (!uns && v[8*nb - 1])
         for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic slot_t idleSlot();
      slot_t s;
      s = '0;
      s.e_rd = model_rd;
      return s;
   endfunction

   function automatic slot_t reqSlot(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic uns, input logic [31:0] addr,
                                     input logic [31:0] wd);
      slot_t s;
      s = idleSlot();
      s.rd = rd; s.wr = wr; s.sz = sz; s.uns = uns; s.addr = addr; s.wd = wd;
      s.e_stall = 1'b1;
      return s;
   endfunction

   task automatic planIdle(input int n);
      for (int i = 0; i < n; i++) begin
         slots[plan_t] = idleSlot();
         plan_t++;
      end
   endtask

   // Load: one IDLE cycle, g+1 REQ cycles (gnt in the last), r WAIT cycles
   // (rvalid in the last), then one RESP cycle where the result appears.
   task automatic planLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] rdata, input int g, input int r);
      slot_t s, b;
      s = reqSlot(1'b1, 1'b0, sz, uns, addr, 32'h0);
      slots[plan_t++] = s;
      for (int i = 0; i <= g; i++) begin
         b = s; b.e_req = 1'b1; b.e_addr = {addr[31:2], 2'b00};
         b.e_be = beOf(sz, addr[1:0]); b.gnt = (i == g);
         slots[plan_t++] = b;
      end
      for (int j = 1; j <= r; j++) begin
         b = s; b.rvalid = (j == r); b.rdata = (j == r) ? rdata : 32'hDEAD_0000;
         slots[plan_t++] = b;
      end
      model_rd = extractOf(sz, uns, addr[1:0], rdata);
      b = s; b.e_stall = 1'b0; b.e_rd = model_rd;
      slots[plan_t++] = b;
   endtask

   task automatic planStore(input logic [31:0] addr, input logic [1:0] sz,
                            input logic [31:0] wd, input int g);
      slot_t s, b;
      s = reqSlot(1'b0, 1'b1, sz, 1'b0, addr, wd);
      slots[plan_t++] = s;
      for (int i = 0; i <= g; i++) begin
         b = s; b.e_req = 1'b1; b.e_we = 1'b1; b.e_addr = {addr[31:2], 2'b00};
         b.e_be = beOf(sz, addr[1:0]); b.e_wdata = lanesOf(sz, wd); b.gnt = (i == g);
         slots[plan_t++] = b;
      end
      b = s; b.e_stall = 1'b0;
      slots[plan_t++] = b;
   endtask

   task automatic planBad(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr);
      slot_t s;
      s = reqSlot(rd, wr, sz, 1'b0, addr, 32'h5555_AAAA);
      s.e_stall = 1'b0; s.e_err = 1'b1;
      model_rd = 32'h0; s.e_rd = 32'h0;
      slots[plan_t++] = s;
   endtask

   // Word load whose grant never comes: 255 REQ cycles then an error RESP
   task automatic planTimeout(input logic [31:0] addr);
      slot_t s, b;
      s = reqSlot(1'b1, 1'b0, 2'b10, 1'b0, addr, 32'h0);
      slots[plan_t++] = s;
      for (int i = 0; i < 255; i++) begin
         b = s; b.e_req = 1'b1; b.e_addr = {addr[31:2], 2'b00}; b.e_be = 4'b1111;
         slots[plan_t++] = b;
      end
      model_rd = 32'h0;
      b = s; b.e_stall = 1'b0; b.e_err = 1'b1; b.e_rd = 32'h0;
      slots[plan_t++] = b;
   endtask

   // Compare every planned cycle against the timeline
   always @(negedge clk) begin
      slot_t e;
      if (running) begin
         e = slots[cur_idx];
         checkOutput("stall", cur_idx, 32'(stall), 32'(e.e_stall));
         checkOutput("bus_req", cur_idx, 32'(bus_req), 32'(e.e_req));
         checkOutput("access_err", cur_idx, 32'(access_err), 32'(e.e_err));
         checkOutput("readdata", cur_idx, readdata, e.e_rd);
         if (e.e_req) begin
            checkOutput("bus_we", cur_idx, 32'(bus_we), 32'(e.e_we));
            checkOutput("bus_addr", cur_idx, bus_addr, e.e_addr);
            checkOutput("bus_be", cur_idx, 32'(bus_be), 32'(e.e_be));
            if (e.e_we) checkOutput("bus_wdata", cur_idx, bus_wdata, e.e_wdata);
         end
         dut_stall[cur_idx] = stall;
         dut_req[cur_idx]   = bus_req;
         dut_err[cur_idx]   = access_err;
         dut_we[cur_idx]    = bus_we;
         dut_be[cur_idx]    = bus_be;
         dut_wdata[cur_idx] = bus_wdata;
         dut_rd[cur_idx]    = readdata;
      end
   end

   initial begin
      int cnt;

      // Reset state, with a request already presented
      memread = 1'b1;
      @(negedge clk);
      checkOutput("rst_readdata", 0, readdata, 32'h0);
      checkOutput("rst_stall", 0, 32'(stall), 32'h0);
      checkOutput("rst_bus_req", 0, 32'(bus_req), 32'h0);
      checkOutput("rst_bus_be", 0, 32'(bus_be), 32'h0);
      checkOutput("rst_access_err", 0, 32'(access_err), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      memread = 1'b0;

      // Plan the directed timeline
      planIdle(1);
      lw_t = plan_t;  planLoad(32'h10, 2'b10, 1'b0, 32'hCAFE_BABE, 0, 1);
      planIdle(1);
      lb_t = plan_t;  planLoad(32'h13, 2'b00, 1'b0, 32'h80FF_0000, 0, 1);
      lbu_t = plan_t; planLoad(32'h13, 2'b00, 1'b1, 32'h80FF_0000, 0, 1);
      planIdle(1);
      sh_t = plan_t;  planStore(32'h22, 2'b01, 32'h1234_ABCD, 0);
      planIdle(1);
      bad_t = plan_t; planBad(1'b1, 1'b0, 2'b10, 32'h21);
      planIdle(1);
      planLoad(32'h02, 2'b01, 1'b0, 32'h8001_7FFF, 2, 2);
      planLoad(32'h00, 2'b01, 1'b1, 32'h8001_7FFF, 0, 3);
      planBad(1'b1, 1'b0, 2'b11, 32'h40);
      planBad(1'b1, 1'b1, 2'b10, 32'h40);
      planBad(1'b0, 1'b1, 2'b01, 32'h03);
      planStore(32'h01, 2'b00, 32'h0000_005A, 2);
      planStore(32'h104, 2'b10, 32'hDEAD_BEEF, 1);
      planLoad(32'h06, 2'b01, 1'b0, 32'h7F00_1234, 1, 1);
      planIdle(2);
      tmo_t = plan_t; planTimeout(32'h40);
      planIdle(1);
      planLoad(32'h0C, 2'b10, 1'b0, 32'h1357_9BDF, 0, 1);
      planIdle(1);

      // Run the timeline
      running = 1'b1;
      for (int k = 0; k < plan_t; k++) begin
         cur_idx = k;
         applyStimulus(slots[k]);
         @(posedge clk); #1;
      end
      running = 1'b0;

      // Literal pins on the planned timeline
      cnt = 0;
      for (int k = lw_t; k <= lw_t + 3; k++) cnt += int'(dut_stall[k]);
      checkOutput("pin_lw_stall_cycles", lw_t, 32'(cnt), 32'd3);
      checkOutput("pin_lw_data", lw_t + 3, dut_rd[lw_t + 3], 32'hCAFE_BABE);
      checkOutput("pin_lb_data", lb_t + 3, dut_rd[lb_t + 3], 32'hFFFF_FF80);
      checkOutput("pin_lbu_data", lbu_t + 3, dut_rd[lbu_t + 3], 32'h0000_0080);
      checkOutput("pin_sh_be", sh_t + 1, 32'(dut_be[sh_t + 1]), 32'(4'b1100));
      checkOutput("pin_sh_wdata", sh_t + 1, dut_wdata[sh_t + 1], 32'hABCD_ABCD);
      checkOutput("pin_sh_we", sh_t + 1, 32'(dut_we[sh_t + 1]), 32'd1);
      checkOutput("pin_bad_req", bad_t + 1, 32'(dut_req[bad_t + 1]), 32'd0);
      checkOutput("pin_bad_err", bad_t, 32'(dut_err[bad_t]), 32'd1);
      checkOutput("pin_bad_stall", bad_t, 32'(dut_stall[bad_t]), 32'd0);
      checkOutput("pin_bad_data", bad_t, dut_rd[bad_t], 32'h0);
      cnt = 0;
      for (int k = tmo_t; k <= tmo_t + 256; k++) cnt += int'(dut_req[k]);
      checkOutput("pin_tmo_req_cycles", tmo_t, 32'(cnt), 32'd255);
      checkOutput("pin_tmo_err", tmo_t + 256, 32'(dut_err[tmo_t + 256]), 32'd1);
      checkOutput("pin_tmo_req_drop", tmo_t + 256, 32'(dut_req[tmo_t + 256]), 32'd0);
      checkOutput("pin_tmo_back_idle", tmo_t + 257, 32'(dut_stall[tmo_t + 257]), 32'd0);

      // Reset while waiting for read data
      memread = 1'b1; mem_size = 2'b10; load_unsigned = 1'b0; alu_result = 32'h50;
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("rstmid_bus_req", 0, 32'(bus_req), 32'h0);
      checkOutput("rstmid_stall", 0, 32'(stall), 32'h0);
      checkOutput("rstmid_readdata", 0, readdata, 32'h0);
      memread = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_rvalid_ignored", 0, readdata, 32'h0);
      checkOutput("rstmid_idle_stall", 0, 32'(stall), 32'h0);
      memread = 1'b1; alu_result = 32'h60;
      @(negedge clk);
      checkOutput("rstmid_new_req_stall", 0, 32'(stall), 32'h1);
      @(posedge clk); #1;
      checkOutput("rstmid_new_bus_req", 0, 32'(bus_req), 32'h1);
      memread = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
